// File: rtl/digit_serial_pkg.sv
// Shared types and the one-bit full adder cell used by the digit-serial adder.
package digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational N-bit ripple adder built from the full adder cell; also exposes
// the carry into its top bit so the caller can form signed overflow.
module digit_adder
    import digit_serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign {w_c[i+1], s[i]} = full_add(x[i], y[i], w_c[i]);
    end

    assign co       = w_c[N];
    assign c_msb_in = w_c[N-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// with valid/ready handshakes on both sides.
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCYC  = WIDTH / DIGIT;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_s;
    logic               w_co;
    logic               w_c_msb;
    logic               w_last;

    digit_adder #(.N(DIGIT)) u_digit_adder (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb)
    );

    assign w_last = (r_cnt == CNT_W'(NCYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // NOTE: datapath registers are reset too (these are flops, not a memory), so no X reaches sum/cout/ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the borrow-in rides on the initial carry.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= WIDTH'({w_s, r_sum} >> DIGIT);
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_c_msb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
